prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Run controller for the single-cycle core. It accepts a level request from the host and holds the core in reset for a programmable number of cycles. It then releases the core and counts execution cycles until the core signals completion. It reports `done` and the cycle count back to the host, and holds them until the host drops its request. It sits between the host/testbench and the core, and owns the core's reset and run enable.

## Interface
- `CW`, 16: cycle counter width.
- `RST_CYC`, 2: cycles `core_reset` is held asserted before the run starts; legal range 1..15.
- `TIMEOUT`, 16'hFFF0: watchdog limit in run cycles; must be < 2^CW.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `req` in 1: host start request, level-sensitive.
- `core_done` in 1: core completion flag (PC at end address).
- `core_reset` out 1: reset to core, active-high.
- `core_run` out 1: core clock enable; core state frozen when low.
- `busy` out 1: sequence in progress (RESET or RUN).
- `done` out 1: program completed normally.
- `timeout` out 1: watchdog fired.
- `cycle_cnt` out CW: run cycles of the last or current run.

## Operation
- States: IDLE, RESET, RUN, DONE, FAULT; all outputs registered.
- IDLE:
  - `core_reset`=1, `core_run`=0, `busy`=0, `done`=0, `timeout`=0.
  - `req`=1 → RESET.
  - `cycle_cnt` holds the previous run's value.
- RESET:
  - `core_reset`=1, `core_run`=0, `busy`=1.
  - 4-bit hold counter loaded with RST_CYC-1 on entry; `cycle_cnt` cleared to 0 on entry.
  - Counter 0 → RUN.
- RUN:
  - `core_reset`=0, `core_run`=1, `busy`=1.
  - `cycle_cnt` +1 per RUN cycle, including the cycle in which `core_done` is sampled.
  - `core_done`=1 → DONE.
  - Watchdog enabled and `cycle_cnt`==TIMEOUT with `core_done`=0 → FAULT.
- DONE:
  - `done`=1, `core_run`=0, `core_reset`=0, so core state stays inspectable.
  - `cycle_cnt` frozen.
  - `req`=0 → IDLE.
- FAULT:
  - `timeout`=1, `core_run`=0, `core_reset`=0, `cycle_cnt` frozen.
  - `req`=0 → IDLE.
- `req` deasserted during RESET or RUN is ignored; the run always completes.
- `req` held high in DONE/FAULT: the state holds. A new run needs `req` low for at least 1 cycle (IDLE), then high.
- `core_done` is ignored outside RUN, including a stale high during RESET.
- `core_done` and watchdog limit in the same cycle: `core_done` wins → DONE.
- `cycle_cnt` saturates at 2^CW-1 and never wraps.

## Timing
- Reset values:
  - state=IDLE, `core_reset`=1, `core_run`=0.
  - `busy`=0, `done`=0, `timeout`=0, `cycle_cnt`=0.
- `reset` asserted in any state → IDLE on the next edge. This covers a mid-run reset; `cycle_cnt` is cleared.
- `req` high at edge t in IDLE:
  - `busy`=1 from t+1.
  - `core_reset` stays high through t+RST_CYC.
  - `core_run`=1 from t+RST_CYC+1.
- `core_done` sampled high at edge u in RUN:
  - `done`=1 and `core_run`=0 from u+1.
  - `cycle_cnt` = number of RUN edges, including u.
- `req` sampled low at edge v in DONE/FAULT: `done`/`timeout`=0 and `core_reset`=1 from v+1.
- `done` and `timeout` are mutually exclusive.

## Configuration
- `PROG_SEQ_WATCHDOG_EN` defined:
  - Watchdog compare active.
  - FAULT reachable.
  - `timeout` driven as above.
- Undefined:
  - No compare logic.
  - FAULT unreachable, `timeout` tied 0.
  - RUN exits only on `core_done` or `reset`.
  - `cycle_cnt` still saturates.

## Test plan
- Reset then idle: `reset`=1 for 2 cycles, `req`=0 → `core_reset`=1, `core_run`=0, `busy`=`done`=`timeout`=0, `cycle_cnt`=0.
- Normal run, RST_CYC=2: `req`↑ at t, `core_done` pulsed on the 50th RUN cycle → `core_reset` high through t+2, `core_run` high t+3..t+52, `done`=1 at t+53, `cycle_cnt`=50. Dropping `req` → IDLE next cycle.
- Watchdog (macro on), TIMEOUT=100, `core_done` never asserted → `timeout`=1 after 100 RUN cycles, `cycle_cnt`=100, `done`=0. Repeat with `core_done`=1 on cycle 100 → `done`=1, `timeout`=0.
- Mid-run reset: `reset` asserted on RUN cycle 20 → IDLE next cycle, `cycle_cnt`=0, `core_reset`=1. A following `req` restarts cleanly.
- `req` handling:
  - `req` dropped on RUN cycle 5 → run continues to `core_done`.
  - `req` held high after DONE → no restart until `req` has been low 1 cycle.
  - Stale `core_done`=1 during RESET → ignored.
- Macro off, CW=4, `core_done` withheld for 20 RUN cycles → `cycle_cnt` saturates at 15, `timeout` stays 0. Then `core_done`=1 → `done`=1.

Source files
------------

// File: rtl/prog_sequencer.sv
// prog_sequencer: core run controller (reset hold, run, cycle count, optional watchdog via PROG_SEQ_WATCHDOG_EN)
module prog_sequencer #(
  parameter int CW      = 16,
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = 16'hFFF0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          core_done,
  output logic          core_reset,
  output logic          core_run,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);
  typedef enum logic [2:0] {IDLE, RESET, RUN, DONE, FAULT} state_t;
  state_t state, state_n;
  logic [3:0] hold, hold_n;
  logic [CW-1:0] cnt_n, cnt_inc;
  logic wd_hit;
  assign cnt_inc = &cycle_cnt ? cycle_cnt : cycle_cnt + CW'(1);
`ifdef PROG_SEQ_WATCHDOG_EN
  assign wd_hit = cnt_inc == CW'(TIMEOUT);
`else
  assign wd_hit = 1'b0;
`endif
  // next state, reset-hold countdown and saturating run counter
  always_comb begin
    state_n = state;
    hold_n  = hold;
    cnt_n   = cycle_cnt;
    case (state)
      IDLE: begin
        state_n = req ? RESET : IDLE;
        hold_n  = req ? 4'(RST_CYC - 1) : hold;
        cnt_n   = req ? '0 : cycle_cnt;
      end
      RESET: begin
        state_n = hold == 4'd0 ? RUN : RESET;
        hold_n  = hold == 4'd0 ? hold : hold - 4'd1;
      end
      RUN: begin
        cnt_n   = cnt_inc;
        state_n = core_done ? DONE : wd_hit ? FAULT : RUN;
      end
      DONE, FAULT: state_n = req ? state : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state register with outputs registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold       <= '0;
      cycle_cnt  <= '0;
      core_reset <= 1'b1;
      core_run   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      hold       <= hold_n;
      cycle_cnt  <= cnt_n;
      core_reset <= state_n == IDLE || state_n == RESET;
      core_run   <= state_n == RUN;
      busy       <= state_n == RESET || state_n == RUN;
      done       <= state_n == DONE;
    end
  end
`ifdef PROG_SEQ_WATCHDOG_EN
  // watchdog flag tracks the FAULT state
  always_ff @(posedge clk) begin
    timeout <= !reset && state_n == FAULT;
  end
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed scoreboard bench for prog_sequencer
module tb_prog_sequencer;
  logic clk = 1'b0;
  logic reset, req, core_done;
  logic core_reset, core_run, busy, done, timeout;
  logic [15:0] cycle_cnt;
  logic s_req, s_core_done;
  logic s_core_reset, s_core_run, s_busy, s_done, s_timeout;
  logic [3:0] s_cnt;
  typedef struct packed {logic d; logic t; logic [15:0] c;} exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prog_sequencer #(.CW(16), .RST_CYC(2), .TIMEOUT(100)) dut (
    .clk(clk), .reset(reset), .req(req), .core_done(core_done),
    .core_reset(core_reset), .core_run(core_run), .busy(busy),
    .done(done), .timeout(timeout), .cycle_cnt(cycle_cnt)
  );

  prog_sequencer #(.CW(4), .RST_CYC(2), .TIMEOUT(15)) dut_sat (
    .clk(clk), .reset(reset), .req(s_req), .core_done(s_core_done),
    .core_reset(s_core_reset), .core_run(s_core_run), .busy(s_busy),
    .done(s_done), .timeout(s_timeout), .cycle_cnt(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_end(input string tag, input logic d, input logic t, input logic [15:0] c);
    exp_t e;
    chk({tag, "_queued"}, 32'(q.size() > 0), 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_done"}, 32'(d), 32'(e.d));
      chk({tag, "_timeout"}, 32'(t), 32'(e.t));
      chk({tag, "_cnt"}, 32'(c), 32'(e.c));
    end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; core_done = 1'b0; s_req = 1'b0; s_core_done = 1'b0;
    step(2);
    chk("rst_core_reset", 32'(core_reset), 1);
    chk("rst_core_run", 32'(core_run), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_cnt", 32'(cycle_cnt), 0);
    chk("rst_sat_cnt", 32'(s_cnt), 0);
    reset = 1'b0;
    step(1);
    chk("idle_core_reset", 32'(core_reset), 1);
    // normal run: 50 run cycles, stale core_done in RESET, req dropped on run cycle 5
    req = 1'b1;
    q.push_back({1'b1, 1'b0, 16'd50});
    step(1);
    chk("n_busy_t1", 32'(busy), 1);
    chk("n_core_reset_t1", 32'(core_reset), 1);
    chk("n_core_run_t1", 32'(core_run), 0);
    core_done = 1'b1;
    step(1);
    chk("stale_core_reset_t2", 32'(core_reset), 1);
    chk("stale_done", 32'(done), 0);
    chk("stale_busy", 32'(busy), 1);
    core_done = 1'b0;
    step(1);
    chk("n_core_run_t3", 32'(core_run), 1);
    chk("n_core_reset_t3", 32'(core_reset), 0);
    chk("n_cnt_run1", 32'(cycle_cnt), 0);
    step(4);
    req = 1'b0;
    step(45);
    chk("n_run_cycle50", 32'(core_run), 1);
    chk("n_cnt_49", 32'(cycle_cnt), 49);
    core_done = 1'b1;
    step(1);
    core_done = 1'b0;
    expect_end("normal", done, timeout, cycle_cnt);
    chk("n_core_run_off", 32'(core_run), 0);
    chk("n_busy_off", 32'(busy), 0);
    step(1);
    chk("n_idle_done", 32'(done), 0);
    chk("n_idle_core_reset", 32'(core_reset), 1);
    chk("n_idle_cnt_hold", 32'(cycle_cnt), 50);
    // req held high after DONE must not restart
    req = 1'b1;
    q.push_back({1'b1, 1'b0, 16'd3});
    step(5);
    core_done = 1'b1;
    step(1);
    core_done = 1'b0;
    expect_end("short", done, timeout, cycle_cnt);
    step(3);
    chk("hold_done", 32'(done), 1);
    chk("hold_busy", 32'(busy), 0);
    req = 1'b0;
    step(1);
    chk("rel_done", 32'(done), 0);
    chk("rel_cnt", 32'(cycle_cnt), 3);
    // restart, then reset on run cycle 20
    req = 1'b1;
    step(1);
    chk("re_busy", 32'(busy), 1);
    chk("re_cnt_clear", 32'(cycle_cnt), 0);
    step(21);
    chk("mid_cnt_19", 32'(cycle_cnt), 19);
    reset = 1'b1;
    req = 1'b0;
    step(1);
    reset = 1'b0;
    chk("mid_core_reset", 32'(core_reset), 1);
    chk("mid_core_run", 32'(core_run), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_cnt", 32'(cycle_cnt), 0);
    // watchdog: core_done withheld
    req = 1'b1;
`ifdef PROG_SEQ_WATCHDOG_EN
    q.push_back({1'b0, 1'b1, 16'd100});
`else
    q.push_back({1'b1, 1'b0, 16'd101});
`endif
    step(3);
    chk("wd_run1", 32'(core_run), 1);
    step(99);
    chk("wd_cnt_99", 32'(cycle_cnt), 99);
    step(1);
`ifndef PROG_SEQ_WATCHDOG_EN
    chk("wd_off_timeout", 32'(timeout), 0);
    chk("wd_off_run", 32'(core_run), 1);
    core_done = 1'b1;
    step(1);
    core_done = 1'b0;
`endif
    expect_end("wdog", done, timeout, cycle_cnt);
    chk("wd_run_off", 32'(core_run), 0);
    req = 1'b0;
    step(1);
    chk("wd_clr_timeout", 32'(timeout), 0);
    chk("wd_clr_core_reset", 32'(core_reset), 1);
    // core_done on the limit cycle wins over the watchdog
    req = 1'b1;
    q.push_back({1'b1, 1'b0, 16'd100});
    step(102);
    core_done = 1'b1;
    step(1);
    core_done = 1'b0;
    expect_end("tie", done, timeout, cycle_cnt);
    req = 1'b0;
    step(1);
    // 4-bit counter saturation on the second instance
    s_req = 1'b1;
`ifdef PROG_SEQ_WATCHDOG_EN
    q.push_back({1'b0, 1'b1, 16'd15});
    step(18);
`else
    q.push_back({1'b1, 1'b0, 16'd15});
    step(23);
    chk("sat_cnt", 32'(s_cnt), 15);
    chk("sat_timeout", 32'(s_timeout), 0);
    chk("sat_run", 32'(s_core_run), 1);
    s_core_done = 1'b1;
    step(1);
    s_core_done = 1'b0;
`endif
    expect_end("sat", s_done, s_timeout, 16'(s_cnt));
    chk("queue_drained", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
